bus_arbiter: RTL and testbench

- Two-master arbiter sharing the single system bus between the core memory path (master 0) and the debug system-bus-access path (master 1).
- Arbitrates with round-robin priority and serialises one transaction at a time.
- Presents the granted request to the bus and returns the response to the winning master only.
- A watchdog counter aborts hung bus transactions with a fault response, so neither the core nor the debugger can deadlock the bus.

---
 rtl/bus_arbiter_if.sv | 50 +++++
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request/response and shared system bus bundle
interface bus_arbiter_if #(
  parameter int Width = 32
);
  logic             m0_req;
  logic             m0_wr;
  logic [2:0]       m0_size;
  logic [Width-1:0] m0_addr;
  logic [Width-1:0] m0_wdata;
  logic             m0_ack;
  logic [Width-1:0] m0_rdata;
  logic             m0_fault;

  logic             m1_req;
  logic             m1_wr;
  logic [2:0]       m1_size;
  logic [Width-1:0] m1_addr;
  logic [Width-1:0] m1_wdata;
  logic             m1_ack;
  logic [Width-1:0] m1_rdata;
  logic             m1_fault;

  logic             bus_req;
  logic             bus_wr;
  logic [2:0]       bus_size;
  logic [Width-1:0] bus_addr;
  logic [Width-1:0] bus_wdata;
  logic             bus_ack;
  logic             bus_err;
  logic [Width-1:0] bus_rdata;

  // The arbiter sits on the slave side of the masters and drives the bus.
  modport slave (
    input  m0_req, m0_wr, m0_size, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_fault,
    input  m1_req, m1_wr, m1_size, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_fault,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport master (
    output m0_req, m0_wr, m0_size, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_fault,
    output m1_req, m1_wr, m1_size, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_fault,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-master bus arbiter with watchdog abort
module bus_arbiter #(
  parameter int Width         = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  bus_arbiter_if.slave bif,
  output logic [1:0]  grant,
  output logic        busy
);
  localparam int CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_d;
  logic             last_grant;
  logic [CntW-1:0]  cnt;
  logic             start, pick, finish;
  logic [Width-1:0] rsp_rdata;
  logic             rsp_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    pick      = 1'b0;
    finish    = 1'b0;
    rsp_rdata = '0;
    rsp_fault = 1'b0;
    case (state)
      IDLE: begin
        if (bif.m0_req || bif.m1_req) begin
          start   = 1'b1;
          pick    = (bif.m0_req && bif.m1_req) ? ~last_grant : bif.m1_req;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A real completion beats the watchdog when both land on the same edge.
        if (bif.bus_ack) begin
          finish    = 1'b1;
          rsp_rdata = bif.bus_wr ? '0 : bif.bus_rdata;
          rsp_fault = bif.bus_err;
          state_d   = RESP;
        end else if (cnt == CntW'(TimeoutCycles - 1)) begin
          finish    = 1'b1;
          rsp_fault = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant    <= 1'b1;
      cnt           <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      bif.bus_req   <= 1'b0;
      bif.bus_wr    <= 1'b0;
      bif.bus_size  <= '0;
      bif.bus_addr  <= '0;
      bif.bus_wdata <= '0;
      bif.m0_ack    <= 1'b0;
      bif.m0_rdata  <= '0;
      bif.m0_fault  <= 1'b0;
      bif.m1_ack    <= 1'b0;
      bif.m1_rdata  <= '0;
      bif.m1_fault  <= 1'b0;
    end else begin
      bif.m0_ack <= 1'b0;
      bif.m1_ack <= 1'b0;
      if (start) begin
        bif.bus_req   <= 1'b1;
        bif.bus_wr    <= pick ? bif.m1_wr    : bif.m0_wr;
        bif.bus_size  <= pick ? bif.m1_size  : bif.m0_size;
        bif.bus_addr  <= pick ? bif.m1_addr  : bif.m0_addr;
        bif.bus_wdata <= pick ? bif.m1_wdata : bif.m0_wdata;
        grant         <= pick ? 2'b10 : 2'b01;
        last_grant    <= pick;
        cnt           <= '0;
        busy          <= 1'b1;
      end
      if (state == BUSY && cnt != CntW'(TimeoutCycles))
        cnt <= cnt + 1'b1;
      if (finish) begin
        bif.bus_req <= 1'b0;
        if (grant[1]) begin
          bif.m1_ack   <= 1'b1;
          bif.m1_rdata <= rsp_rdata;
          bif.m1_fault <= rsp_fault;
        end else begin
          bif.m0_ack   <= 1'b1;
          bif.m0_rdata <= rsp_rdata;
          bif.m0_fault <= rsp_fault;
        end
      end
      if (state == RESP) begin
        grant <= '0;
        busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       busy;

  bus_arbiter_if #(.Width(32)) bif ();

  bus_arbiter #(.Width(32), .TimeoutCycles(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bif  (bif),
    .grant(grant),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    logic [31:0] rdata;
    logic        fault;
  } resp_t;

  resp_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  bit          hold0 = 0, hold1 = 0;
  bit          resp_en = 0, resp_err = 0, resp_mix = 0, stray = 0;
  int          resp_delay = 0, wait_cnt = 0;
  logic [31:0] resp_data = '0;
  logic        prev0 = 0, prev1 = 0;

  // Bus slave model: acks resp_delay negedges after bus_req is first seen.
  always @(negedge clk) begin
    bif.bus_ack   = 1'b0;
    bif.bus_err   = 1'b0;
    bif.bus_rdata = '0;
    if (stray) begin
      bif.bus_ack   = 1'b1;
      bif.bus_err   = 1'b1;
      bif.bus_rdata = 32'hFFFF_FFFF;
      stray = 0;
    end else if (bif.bus_req && resp_en) begin
      if (wait_cnt == resp_delay) begin
        bif.bus_ack   = 1'b1;
        bif.bus_err   = resp_err;
        bif.bus_rdata = resp_data + (resp_mix ? bif.bus_addr : 32'h0);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (bif.m0_ack && !hold0) bif.m0_req = 1'b0;
    if (bif.m1_ack && !hold1) bif.m1_req = 1'b0;
  end

  // Response monitor: every ack pops the scoreboard.
  always @(negedge clk) begin
    resp_t e;
    logic [31:0] rd;
    logic        ft;
    if (rst_n && (bif.m0_ack || bif.m1_ack)) begin
      n_vec++;
      if (bif.m0_ack && bif.m1_ack) begin
        n_bad++;
        $display("FAIL dual_ack: m0_ack=%0b m1_ack=%0b, required only one", bif.m0_ack, bif.m1_ack);
      end
      if ((bif.m0_ack && prev0) || (bif.m1_ack && prev1)) begin
        n_bad++;
        $display("FAIL ack_width: ack high two cycles, required one-cycle pulse");
      end
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b, required none", bif.m0_ack, bif.m1_ack);
      end else begin
        e  = sb.pop_front();
        rd = bif.m1_ack ? bif.m1_rdata : bif.m0_rdata;
        ft = bif.m1_ack ? bif.m1_fault : bif.m0_fault;
        n_vec += 3;
        if (bif.m1_ack !== e.m) begin
          n_bad++;
          $display("FAIL ack_master: got m%0d, required m%0d", bif.m1_ack, e.m);
        end
        if (rd !== e.rdata) begin
          n_bad++;
          $display("FAIL ack_rdata: got %h, required %h", rd, e.rdata);
        end
        if (ft !== e.fault) begin
          n_bad++;
          $display("FAIL ack_fault: got %0b, required %0b", ft, e.fault);
        end
      end
    end
    prev0 = bif.m0_ack;
    prev1 = bif.m1_ack;
  end

  task automatic drive_req(input bit m, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    if (!m) begin
      bif.m0_wr = wr; bif.m0_size = 3'b010; bif.m0_addr = addr;
      bif.m0_wdata = wdata; bif.m0_req = 1'b1;
    end else begin
      bif.m1_wr = wr; bif.m1_size = 3'b101; bif.m1_addr = addr;
      bif.m1_wdata = wdata; bif.m1_req = 1'b1;
    end
  endtask

  task automatic push_exp(input bit m, input logic [31:0] rdata, input logic fault);
    resp_t e;
    e.m = m; e.rdata = rdata; e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic wait_done(output int req_cycles);
    int i;
    req_cycles = 0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bif.bus_req) req_cycles++;
      if (!busy && sb.size() == 0) break;
    end
    if (i == 100) begin
      n_vec++; n_bad++;
      $display("FAIL wait_done: still busy=%0b pending=%0d after 100 cycles, required idle", busy, sb.size());
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; hold0 = 0; hold1 = 0;
    bif.m0_req = 0; bif.m1_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bif.m0_req = 0; bif.m0_wr = 0; bif.m0_size = 0; bif.m0_addr = 0; bif.m0_wdata = 0;
    bif.m1_req = 0; bif.m1_wr = 0; bif.m1_size = 0; bif.m1_addr = 0; bif.m1_wdata = 0;
    apply_reset();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_bus_req", 32'(bif.bus_req), 32'h0);
    check("reset_bus_addr", bif.bus_addr, 32'h0);
    check("reset_m0_ack", 32'(bif.m0_ack), 32'h0);
    check("reset_m1_rdata", bif.m1_rdata, 32'h0);
  endtask

  task automatic test_single_read();
    int rc;
    resp_en = 1; resp_delay = 2; resp_err = 0; resp_mix = 0; resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    push_exp(0, 32'hDEAD_BEEF, 1'b0);
    drive_req(0, 0, 32'h1000, 32'h0);
    @(negedge clk);
    check("single_grant", 32'(grant), 32'h1);
    check("single_bus_req", 32'(bif.bus_req), 32'h1);
    check("single_bus_addr", bif.bus_addr, 32'h1000);
    check("single_bus_size", 32'(bif.bus_size), 32'h2);
    check("single_bus_wr", 32'(bif.bus_wr), 32'h0);
    wait_done(rc);
    check("single_m1_rdata_untouched", bif.m1_rdata, 32'h0);
  endtask

  task automatic test_tie_alternate();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] gseq  [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] pg = 2'b00;
    int ng = 0;
    int rc;
    apply_reset();
    resp_en = 1; resp_delay = 1; resp_err = 0; resp_mix = 1; resp_data = 32'h1111_0000;
    hold0 = 1; hold1 = 1;
    push_exp(0, 32'h1111_0100, 0); push_exp(1, 32'h1111_0200, 0);
    push_exp(0, 32'h1111_0100, 0); push_exp(1, 32'h1111_0200, 0);
    drive_req(0, 0, 32'h100, 32'h0);
    drive_req(1, 0, 32'h200, 32'h0);
    for (int c = 0; c < 80 && ng < 4; c++) begin
      @(negedge clk);
      if (grant != 2'b00 && pg == 2'b00) begin
        gseq[ng] = grant;
        ng++;
        if (ng == 4) begin
          bif.m0_req = 1'b0;
          hold0 = 0;
          hold1 = 0;
        end
      end
      pg = grant;
    end
    for (int k = 0; k < 4; k++) check($sformatf("tie_grant%0d", k), 32'(gseq[k]), 32'(exp_g[k]));
    wait_done(rc);
  endtask

  task automatic test_bus_error();
    int rc;
    resp_en = 1; resp_delay = 0; resp_err = 1; resp_mix = 0; resp_data = 32'hCAFE_0000;
    push_exp(1, 32'h0, 1'b1);
    drive_req(1, 1, 32'h2000, 32'h55AA_55AA);
    @(negedge clk);
    check("err_grant", 32'(grant), 32'h2);
    check("err_bus_wr", 32'(bif.bus_wr), 32'h1);
    check("err_bus_wdata", bif.bus_wdata, 32'h55AA_55AA);
    check("err_bus_size", 32'(bif.bus_size), 32'h5);
    wait_done(rc);
    check("err_m0_rdata_untouched", bif.m0_rdata, 32'h1111_0100);
    check("err_m0_fault_untouched", 32'(bif.m0_fault), 32'h0);
    resp_err = 0;
  endtask

  task automatic test_timeout();
    int rc;
    resp_en = 0;
    push_exp(0, 32'h0, 1'b1);
    drive_req(0, 0, 32'h3000, 32'h0);
    wait_done(rc);
    check("timeout_req_cycles", 32'(rc), 32'd4);
    resp_en = 1; resp_delay = 3; resp_mix = 0; resp_data = 32'h1234_5678;
    push_exp(0, 32'h1234_5678, 1'b0);
    drive_req(0, 0, 32'h3004, 32'h0);
    wait_done(rc);
    check("late_ack_req_cycles", 32'(rc), 32'd4);
  endtask

  task automatic test_reset_mid_busy();
    int rc;
    resp_en = 0;
    drive_req(0, 0, 32'h4000, 32'h0);
    @(negedge clk);
    check("midrst_bus_req_before", 32'(bif.bus_req), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bus_req", 32'(bif.bus_req), 32'h0);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_m0_ack", 32'(bif.m0_ack), 32'h0);
    rst_n = 1'b1;
    bif.m0_req = 1'b0;
    @(negedge clk);
    resp_en = 1; resp_delay = 0; resp_data = 32'h0BAD_0000; resp_mix = 1;
    push_exp(0, 32'h0BAD_0500, 0);
    push_exp(1, 32'h0BAD_0600, 0);
    drive_req(0, 0, 32'h500, 32'h0);
    drive_req(1, 0, 32'h600, 32'h0);
    @(negedge clk);
    check("midrst_tie_grant", 32'(grant), 32'h1);
    wait_done(rc);
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    stray = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stray_busy%0d", c), 32'(busy), 32'h0);
      check($sformatf("stray_grant%0d", c), 32'(grant), 32'h0);
      check($sformatf("stray_bus_req%0d", c), 32'(bif.bus_req), 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_alternate();
    test_bus_error();
    test_timeout();
    test_reset_mid_busy();
    test_stray_ack();
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
